// File: rtl/mips20_prog_loader.sv
// MIPS20 program loader: framed byte stream -> big-endian words -> memory write port.
// Optional trailing XOR checksum byte when MIPS20_LOADER_CHECKSUM_EN is defined.
module mips20_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              error,
    output logic [15:0]       word_count
);

`ifdef MIPS20_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_DATA, S_CKSUM, S_FLUSH, S_DONE, S_ERR
    } state_t;
    localparam state_t S_TAIL = S_CKSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_DATA, S_FLUSH, S_DONE, S_ERR
    } state_t;
    localparam state_t S_TAIL = S_FLUSH;
`endif

    localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         word_q, word_d;
    logic [15:0]         wc_q, wc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
`ifdef MIPS20_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                acc;
    logic [15:0]         n_len;

    assign acc   = in_valid & in_ready;
    assign n_len = {len_hi_q, in_data};

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            S_IDLE, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef MIPS20_LOADER_CHECKSUM_EN
            S_CKSUM:                  in_ready = 1'b1;
`endif
            default:                  in_ready = 1'b0;
        endcase
    end

    assign cpu_run    = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign busy       = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = wc_q;

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        wc_d     = wc_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef MIPS20_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    len_d  = n_len;
                    bcnt_d = 2'd0;
`ifdef MIPS20_LOADER_CHECKSUM_EN
                    csum_d = 8'h00;
`endif
                    if ({1'b0, n_len} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else if (n_len == 16'd0) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    word_d = {word_q[15:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef MIPS20_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    // Fourth byte completes the word; the write strobe follows the accepting edge.
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = BASE_L + wc_q[ADDR_W-1:0];
                        wdata_d = {word_q, in_data};
                        wc_d    = wc_q + 16'd1;
                        if (wc_q + 16'd1 == len_q) begin
                            state_d = S_TAIL;
                        end
                    end
                end
            end
`ifdef MIPS20_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (acc) begin
                    state_d = (in_data == csum_q) ? S_FLUSH : S_ERR;
                end
            end
`endif
            S_FLUSH: state_d = S_DONE;
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_IDLE;
                    wc_d    = 16'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_hi_q <= 8'h00;
            len_q    <= 16'd0;
            bcnt_q   <= 2'd0;
            word_q   <= 24'd0;
            wc_q     <= 16'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
`ifdef MIPS20_LOADER_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            wc_q     <= wc_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef MIPS20_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_mips20_prog_loader.sv
// Bench for mips20_prog_loader: byte-position frame model, per-cycle compare, random frames.
module tb_mips20_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int BASE   = 0;
`ifdef MIPS20_LOADER_CHECKSUM_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic              clk1 = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              error;
    logic [15:0]       word_count;

    always #5 clk1 = ~clk1;

    mips20_prog_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk1(clk1),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .start(start),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_run(cpu_run),
        .busy(busy),
        .error(error),
        .word_count(word_count)
    );

    // Model: frame progress is tracked as the count of bytes accepted so far.
    int          pos = 0;
    int          n_len = 0;
    int          wc = 0;
    bit          m_flush = 0, m_done = 0, m_err = 0, m_we = 0, m_acc = 0;
    logic [7:0]  hi = 0, x = 0;
    logic [31:0] word = 0, m_data = 0;
    int          m_addr = 0;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit chk_en = 0;
    logic [ADDR_W-1:0] wr_a[$];
    logic [31:0]       wr_d[$];
    logic [7:0]        fb[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad < 40)
                $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic bit m_rdy();
        return !m_flush && !m_done && !m_err;
    endfunction

    task automatic model_step();
        bit acc;
        int p;
        acc   = in_valid && m_rdy();
        m_acc = 0;
        m_we  = 0;
        if (rst) begin
            pos = 0; wc = 0; m_flush = 0; m_done = 0; m_err = 0;
            m_addr = 0; m_data = 0;
            return;
        end
        if (m_flush) begin
            m_flush = 0;
            m_done  = 1;
        end else if (m_done || m_err) begin
            if (start) begin
                m_done = 0; m_err = 0; pos = 0; wc = 0;
            end
        end else if (acc) begin
            m_acc = 1;
            pos++;
            p = pos;
            if (p == 1) begin
                hi = in_data;
            end else if (p == 2) begin
                n_len = {hi, in_data};
                x = 0;
                word = 0;
                if (n_len > DEPTH) m_err = 1;
                else if (n_len == 0 && !EN) m_flush = 1;
            end else if (p <= 2 + 4 * n_len) begin
                word = {word[23:0], in_data};
                x ^= in_data;
                if ((p - 2) % 4 == 0) begin
                    m_we = 1;
                    m_addr = (BASE + wc) % (1 << ADDR_W);
                    m_data = word;
                    wc++;
                    if (p == 2 + 4 * n_len && !EN) m_flush = 1;
                end
            end else begin
                if (in_data == x) m_flush = 1;
                else m_err = 1;
            end
        end
    endtask

    always @(negedge clk1) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy()});
            chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
            chk("mem_addr", 32'(mem_addr), 32'(m_addr[ADDR_W-1:0]));
            chk("mem_wdata", mem_wdata, m_data);
            chk("cpu_run", {31'd0, cpu_run}, {31'd0, m_done});
            chk("busy", {31'd0, busy},
                {31'd0, m_flush || (pos > 0 && !m_done && !m_err)});
            chk("error", {31'd0, error}, {31'd0, m_err});
            chk("word_count", {16'd0, word_count}, 32'(wc[15:0]));
            if (mem_we) begin
                wr_a.push_back(mem_addr);
                wr_d.push_back(mem_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] b, input int mode);
        bit ok;
        ok = 0;
        if (mode == 2) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 0;
                tick();
            end
        end
        in_valid = 1;
        in_data  = b;
        for (int i = 0; i < 40; i++) begin
            start = (i == 0) && (mode == 2) && ($urandom_range(0, 15) == 0);
            tick();
            start = 0;
            if (m_acc) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout cyc=%0d actual=stalled required=accepted", cyc);
        end
        in_valid = 0;
        if (mode == 1) tick();
    endtask

    task automatic run_frame(input int mode);
        foreach (fb[i]) send(fb[i], mode);
    endtask

    function automatic logic [7:0] ck();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 2; i < fb.size(); i++) r ^= fb[i];
        return r;
    endfunction

    task automatic build(input int n, input bit bad);
        logic [7:0] c;
        fb.delete();
        fb.push_back(8'(n >> 8));
        fb.push_back(8'(n));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) fb.push_back(8'($urandom));
            if (EN) begin
                c = ck();
                if (bad) c ^= 8'($urandom_range(1, 255));
                fb.push_back(c);
            end
        end
    endtask

    task automatic rearm();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic clr_wr();
        wr_a.delete();
        wr_d.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int mode;
        int k;
        rst = 1; in_valid = 0; in_data = 0; start = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_run", {31'd0, cpu_run}, 32'd0);
        chk("rst_wc", {16'd0, word_count}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);

        // reset held two cycles in the middle of a word
        clr_wr();
        fb = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00};
        run_frame(0);
        in_valid = 1;
        in_data  = 8'h05;
        rst = 1;
        tick();
        tick();
        rst = 0;
        in_valid = 0;
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_wc", {16'd0, word_count}, 32'd0);
        chk("t1_nowr", wr_a.size(), 32'd0);
        chk("t1_addr", 32'(mem_addr), 32'd0);

        // reference frame, in_valid held high, then toggled
        for (int t = 0; t < 2; t++) begin
            clr_wr();
            fb = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h05,
                   8'hFC, 8'h00, 8'h00, 8'h00};
`ifdef MIPS20_LOADER_CHECKSUM_EN
            fb.push_back(ck());
`endif
            run_frame(t);
            if (t == 0) begin
                chk("t2_run0", {31'd0, cpu_run}, 32'd0);
                tick();
            end
            chk("t2_run1", {31'd0, cpu_run}, 32'd1);
            chk("t2_wc", {16'd0, word_count}, 32'd2);
            chk("t2_nwr", wr_a.size(), 32'd2);
            if (wr_a.size() == 2) begin
                chk("t2_a0", 32'(wr_a[0]), 32'd0);
                chk("t2_d0", wr_d[0], 32'h28010005);
                chk("t2_a1", 32'(wr_a[1]), 32'd1);
                chk("t2_d1", wr_d[1], 32'hFC000000);
            end
            in_valid = 1;
            in_data  = 8'h77;
            tick();
            tick();
            in_valid = 0;
            chk("t2_stall_wc", {16'd0, word_count}, 32'd2);
            rearm();
            chk("t2_rearm_run", {31'd0, cpu_run}, 32'd0);
            chk("t2_rearm_wc", {16'd0, word_count}, 32'd0);
        end

        // oversize length
        clr_wr();
        fb = '{8'h04, 8'h01};
        run_frame(0);
        chk("t4_err", {31'd0, error}, 32'd1);
        tick();
        chk("t4_nowr", wr_a.size(), 32'd0);
        rearm();
        chk("t4_clr", {31'd0, error}, 32'd0);
        chk("t4_idle", {31'd0, busy}, 32'd0);

`ifdef MIPS20_LOADER_CHECKSUM_EN
        // bad checksum: word still written, then error
        clr_wr();
        fb = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        run_frame(0);
        chk("t5_err", {31'd0, error}, 32'd1);
        chk("t5_run", {31'd0, cpu_run}, 32'd0);
        chk("t5_nwr", wr_a.size(), 32'd1);
        if (wr_d.size() == 1) chk("t5_d0", wr_d[0], 32'h11223344);
        rearm();
`endif

        // empty frame, then start racing a byte in DONE
        clr_wr();
        fb = '{8'h00, 8'h00};
`ifdef MIPS20_LOADER_CHECKSUM_EN
        fb.push_back(8'h00);
`endif
        run_frame(0);
        tick();
        chk("t6_run", {31'd0, cpu_run}, 32'd1);
        chk("t6_nwr", wr_a.size(), 32'd0);
        start = 1;
        in_valid = 1;
        in_data = 8'hAB;
        tick();
        start = 0;
        in_valid = 0;
        chk("t6_idle_run", {31'd0, cpu_run}, 32'd0);
        chk("t6_idle_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("t6_not_taken", {31'd0, busy}, 32'd0);

        // randomized frames
        for (int it = 0; it < 40; it++) begin
            n = ($urandom_range(0, 9) == 0) ? 1025 + $urandom_range(0, 500)
                                            : $urandom_range(0, 6);
            build(n, EN && ($urandom_range(0, 3) == 0));
            mode = $urandom_range(0, 2);
            if (it % 7 == 3) begin
                k = $urandom_range(1, fb.size() - 1);
                for (int i = 0; i < k; i++) send(fb[i], mode);
                in_valid = 1;
                in_data = 8'($urandom);
                rst = 1;
                tick();
                tick();
                rst = 0;
                in_valid = 0;
                tick();
                continue;
            end
            run_frame(mode);
            repeat (3) begin
                in_valid = 1'($urandom);
                in_data = 8'($urandom);
                tick();
            end
            in_valid = 1'($urandom);
            rearm();
            in_valid = 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
